// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// cdb_arbiter : round-robin arbiter of NUM_REQ producers onto the 4-lane CDB
// Rev 1.0
// ============================================================================
module cdb_arbiter #(
   parameter int NUM_REQ    = 6,
   parameter int STARVE_MAX = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic [NUM_REQ-1:0]    req_valid_i,
   input  logic [4*NUM_REQ-1:0]  req_rob_index_i,
   input  logic [16*NUM_REQ-1:0] req_result_i,
   output logic [NUM_REQ-1:0]    req_ready_o,
   output logic                  cdb_valid_o     [0:3],
   output logic [3:0]            cdb_rob_index_o [0:3],
   output logic [15:0]           cdb_result_o    [0:3],
   output logic                  starve_flag_o,
   output logic [2:0]            grant_count_o
);
   localparam int C_LANES = 4;
   localparam int C_PTR_W = $clog2(NUM_REQ);

   logic [C_PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [3:0]         wait_cnt_q [NUM_REQ];
   logic [3:0]         wait_cnt_d [NUM_REQ];
   logic               cdb_valid_q [C_LANES];
   logic [3:0]         cdb_idx_q   [C_LANES];
   logic [15:0]        cdb_res_q   [C_LANES];
   logic               starve_q, starve_d;
   logic [2:0]         gcnt_q, n_grant;
   logic [C_PTR_W-1:0] lane_src [C_LANES];
   logic [C_PTR_W-1:0] sel;

   function automatic logic [C_PTR_W-1:0] wrap_add(input logic [C_PTR_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return C_PTR_W'(sum);
   endfunction

   always_comb begin
      req_ready_o = '0;
      n_grant     = '0;
      rr_ptr_d    = rr_ptr_q;
      sel         = '0;
      starve_d    = 1'b0;
      for (int l = 0; l < C_LANES; l++) lane_src[l] = '0;
      // Scan from the pointer; the k-th grant in scan order owns lane k.
      if (!rst && !flush_i) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            sel = wrap_add(rr_ptr_q, k);
            if (req_valid_i[sel] && (n_grant < 3'(C_LANES))) begin
               req_ready_o[sel]        = 1'b1;
               lane_src[n_grant[1:0]]  = sel;
               n_grant                 = n_grant + 3'd1;
               rr_ptr_d                = wrap_add(sel, 1);
            end
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (flush_i)
            wait_cnt_d[i] = '0;
         else if (req_valid_i[i] && !req_ready_o[i])
            wait_cnt_d[i] = (wait_cnt_q[i] == 4'hF) ? 4'hF : wait_cnt_q[i] + 4'd1;
         else
            wait_cnt_d[i] = '0;
         if (int'(wait_cnt_d[i]) >= STARVE_MAX) starve_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
         starve_q <= 1'b0;
         gcnt_q   <= '0;
         for (int l = 0; l < C_LANES; l++) begin
            cdb_valid_q[l] <= 1'b0;
            cdb_idx_q[l]   <= '0;
            cdb_res_q[l]   <= '0;
         end
         for (int i = 0; i < NUM_REQ; i++) wait_cnt_q[i] <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         starve_q <= starve_d;
         gcnt_q   <= n_grant;
         // Unused lanes drop valid but keep their last payload.
         for (int l = 0; l < C_LANES; l++) begin
            cdb_valid_q[l] <= (3'(l) < n_grant);
            if (3'(l) < n_grant) begin
               cdb_idx_q[l] <= req_rob_index_i[4*lane_src[l] +: 4];
               cdb_res_q[l] <= req_result_i[16*lane_src[l] +: 16];
            end
         end
         for (int i = 0; i < NUM_REQ; i++) wait_cnt_q[i] <= wait_cnt_d[i];
      end
   end

   assign cdb_valid_o     = cdb_valid_q;
   assign cdb_rob_index_o = cdb_idx_q;
   assign cdb_result_o    = cdb_res_q;
   assign starve_flag_o   = starve_q;
   assign grant_count_o   = gcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// tb_cdb_arbiter : scoreboard bench; 6-producer main DUT plus a 15-producer
// instance with a short starvation threshold.
module tb_cdb_arbiter;
   localparam int N = 6;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            flush = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [4*N-1:0]  req_rob_index = '0;
   logic [16*N-1:0] req_result = '0;
   logic [N-1:0]    req_ready;
   logic            cdb_valid     [0:3];
   logic [3:0]      cdb_rob_index [0:3];
   logic [15:0]     cdb_result    [0:3];
   logic            starve_flag;
   logic [2:0]      grant_count;

   logic [14:0]     s_valid = '0;
   logic [59:0]     s_idx = '0;
   logic [239:0]    s_res = '0;
   logic [14:0]     s_ready;
   logic            s_cdb_valid [0:3];
   logic [3:0]      s_cdb_idx   [0:3];
   logic [15:0]     s_cdb_res   [0:3];
   logic            s_starve;
   logic [2:0]      s_gc;

   always #5 clk = ~clk;

   cdb_arbiter #(.NUM_REQ(N), .STARVE_MAX(15)) dut (
      .clk(clk), .rst(rst), .flush_i(flush),
      .req_valid_i(req_valid), .req_rob_index_i(req_rob_index), .req_result_i(req_result),
      .req_ready_o(req_ready), .cdb_valid_o(cdb_valid), .cdb_rob_index_o(cdb_rob_index),
      .cdb_result_o(cdb_result), .starve_flag_o(starve_flag), .grant_count_o(grant_count));

   cdb_arbiter #(.NUM_REQ(15), .STARVE_MAX(3)) dut_starve (
      .clk(clk), .rst(rst), .flush_i(1'b0),
      .req_valid_i(s_valid), .req_rob_index_i(s_idx), .req_result_i(s_res),
      .req_ready_o(s_ready), .cdb_valid_o(s_cdb_valid), .cdb_rob_index_o(s_cdb_idx),
      .cdb_result_o(s_cdb_res), .starve_flag_o(s_starve), .grant_count_o(s_gc));

   typedef struct packed {
      logic [3:0]       v;
      logic [3:0][3:0]  idx;
      logic [3:0][15:0] res;
      logic [2:0]       gc;
   } exp_t;

   exp_t             sb [$];
   int               checks = 0;
   int               errors = 0;
   int               m_ptr = 0;
   logic [3:0][3:0]  m_idx = '0;
   logic [3:0][15:0] m_res = '0;
   logic [3:0]       p_idx [N];
   logic [15:0]      p_res [N];

   // Two reservation-station entries snooping the CDB for ROB tags 7 and 9.
   localparam logic [3:0] RS_TAG0 = 4'd7;
   localparam logic [3:0] RS_TAG1 = 4'd9;
   logic        rs_rdy [2];
   logic [15:0] rs_val [2];
   always @(posedge clk) begin
      if (rst) begin
         rs_rdy[0] <= 1'b0;
         rs_rdy[1] <= 1'b0;
      end else begin
         for (int l = 0; l < 4; l++) begin
            if (!rs_rdy[0] && cdb_valid[l] && cdb_rob_index[l] == RS_TAG0) begin
               rs_rdy[0] <= 1'b1; rs_val[0] <= cdb_result[l];
            end
            if (!rs_rdy[1] && cdb_valid[l] && cdb_rob_index[l] == RS_TAG1) begin
               rs_rdy[1] <= 1'b1; rs_val[1] <= cdb_result[l];
            end
         end
      end
   end

   // Drive one cycle of stimulus and push the expected CDB state for the next edge.
   task automatic drive(input logic r, input logic f, input logic [N-1:0] v, output logic [N-1:0] er);
      exp_t e;
      int   n;
      int   last;
      @(negedge clk);
      rst = r; flush = f; req_valid = v;
      for (int i = 0; i < N; i++) begin
         req_rob_index[4*i +: 4] = p_idx[i];
         req_result[16*i +: 16]  = p_res[i];
      end
      #1;
      er = '0; n = 0; last = 0; e = '0;
      if (r) begin
         m_ptr = 0; m_idx = '0; m_res = '0;
      end else if (!f) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (v[j] && n < 4) begin
               er[j] = 1'b1; e.v[n] = 1'b1;
               m_idx[n] = p_idx[j]; m_res[n] = p_res[j];
               n++; last = j;
            end
         end
         if (n > 0) m_ptr = (last + 1) % N;
      end
      e.idx = m_idx; e.res = m_res; e.gc = 3'(n);
      sb.push_back(e);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int l = 0; l < 4; l++) begin
               checks++;
               if (cdb_valid[l] !== e.v[l] || cdb_rob_index[l] !== e.idx[l] || cdb_result[l] !== e.res[l]) begin
                  errors++;
                  $display("FAIL cdb_lane%0d: got v=%0b idx=%h res=%h, want v=%0b idx=%h res=%h", l,
                           cdb_valid[l], cdb_rob_index[l], cdb_result[l], e.v[l], e.idx[l], e.res[l]);
               end
            end
            checks++;
            if (grant_count !== e.gc) begin
               errors++;
               $display("FAIL grant_count: got %0d, want %0d", grant_count, e.gc);
            end
         end
      end
   end

   task automatic test_reset();
      logic [N-1:0] er;
      for (int i = 0; i < N; i++) begin p_idx[i] = 4'(i + 1); p_res[i] = 16'(16'h1100 * (i + 1)); end
      drive(1'b1, 1'b0, 6'h3F, er);
      checks++;
      if (req_ready !== 6'h00) begin errors++; $display("FAIL reset_ready: got %b, want 000000", req_ready); end
      drive(1'b1, 1'b1, 6'h3F, er);
      checks++;
      if (req_ready !== 6'h00) begin errors++; $display("FAIL rst_flush_ready: got %b, want 000000", req_ready); end
      checks++;
      if (starve_flag !== 1'b0) begin errors++; $display("FAIL reset_starve: got %b, want 0", starve_flag); end
      drive(1'b0, 1'b0, 6'h3F, er);
      checks++;
      if (req_ready !== 6'h0F) begin errors++; $display("FAIL reset_release_ready: got %b, want 001111", req_ready); end
   endtask

   task automatic test_single();
      logic [N-1:0] er;
      drive(1'b1, 1'b0, 6'h00, er);
      p_idx[2] = 4'h5; p_res[2] = 16'hBEEF;
      drive(1'b0, 1'b0, 6'b000100, er);
      checks++;
      if (req_ready !== 6'b000100) begin errors++; $display("FAIL single_ready: got %b, want 000100", req_ready); end
      drive(1'b0, 1'b0, 6'h3F, er);
      checks++;
      if (req_ready !== 6'b111001) begin errors++; $display("FAIL single_next_ptr: got %b, want 111001", req_ready); end
   endtask

   task automatic test_oversub();
      logic [N-1:0] er;
      drive(1'b1, 1'b0, 6'h00, er);
      for (int i = 0; i < N; i++) begin p_idx[i] = 4'(8 + i); p_res[i] = 16'(16'hA000 + i); end
      drive(1'b0, 1'b0, 6'h3F, er);
      checks++;
      if (req_ready !== 6'h0F) begin errors++; $display("FAIL oversub_c0: got %b, want 001111", req_ready); end
      drive(1'b0, 1'b0, 6'h3F, er);
      checks++;
      if (req_ready !== 6'b110011) begin errors++; $display("FAIL oversub_c1: got %b, want 110011", req_ready); end
      @(posedge clk); #2;
      checks++;
      if (cdb_rob_index[0] !== 4'hC || cdb_rob_index[1] !== 4'hD || cdb_rob_index[2] !== 4'h8 || cdb_rob_index[3] !== 4'h9) begin
         errors++;
         $display("FAIL oversub_lane_order: got %h %h %h %h, want c d 8 9",
                  cdb_rob_index[0], cdb_rob_index[1], cdb_rob_index[2], cdb_rob_index[3]);
      end
   endtask

   task automatic test_flush();
      logic [N-1:0] er;
      drive(1'b0, 1'b1, 6'b000111, er);
      checks++;
      if (req_ready !== 6'h00) begin errors++; $display("FAIL flush_ready: got %b, want 000000", req_ready); end
      drive(1'b0, 1'b0, 6'b000111, er);
      checks++;
      if (req_ready !== 6'b000111) begin errors++; $display("FAIL flush_after: got %b, want 000111", req_ready); end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] er;
      logic [N-1:0] pend;
      logic         r, f;
      pend = '0;
      drive(1'b1, 1'b0, 6'h00, er);
      for (int c = 0; c < 60; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) != 0) begin
               pend[i] = 1'b1; p_idx[i] = 4'($urandom); p_res[i] = 16'($urandom);
            end
         end
         r = ($urandom_range(0, 24) == 0);
         f = ($urandom_range(0, 7) == 0);
         drive(r, f, pend, er);
         checks++;
         if (req_ready !== er) begin errors++; $display("FAIL b2b_ready c%0d: got %b, want %b", c, req_ready, er); end
         pend = pend & ~er;
      end
   endtask

   task automatic test_starvation();
      logic [N-1:0]  er;
      logic [14:0]   sv;
      logic [14:0]   exp_rdy [4];
      logic          exp_flag [4];
      logic [2:0]    exp_gc [4];
      exp_rdy  = '{15'h000F, 15'h00F0, 15'h0F00, 15'h4000};
      exp_flag = '{1'b0, 1'b0, 1'b1, 1'b0};
      exp_gc   = '{3'd4, 3'd4, 3'd4, 3'd1};
      for (int i = 0; i < 15; i++) begin s_idx[4*i +: 4] = 4'(i); s_res[16*i +: 16] = 16'(16'hC000 + i); end
      drive(1'b1, 1'b0, 6'h00, er);
      sv = 15'h4FFF;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         rst = 1'b0; req_valid = '0; s_valid = sv;
         #1;
         checks++;
         if (s_ready !== exp_rdy[c]) begin errors++; $display("FAIL starve_ready c%0d: got %h, want %h", c, s_ready, exp_rdy[c]); end
         sv = sv & ~exp_rdy[c];
         @(posedge clk); #1;
         checks++;
         if (s_starve !== exp_flag[c]) begin errors++; $display("FAIL starve_flag c%0d: got %b, want %b", c, s_starve, exp_flag[c]); end
         checks++;
         if (s_gc !== exp_gc[c]) begin errors++; $display("FAIL starve_gc c%0d: got %0d, want %0d", c, s_gc, exp_gc[c]); end
      end
      @(negedge clk);
      s_valid = '0;
   endtask

   task automatic test_integration();
      logic [N-1:0] er;
      drive(1'b1, 1'b0, 6'h00, er);
      p_idx[1] = 4'd7; p_res[1] = 16'h1234;
      p_idx[4] = 4'd9; p_res[4] = 16'h5678;
      drive(1'b0, 1'b0, 6'b010010, er);
      checks++;
      if (req_ready !== 6'b010010) begin errors++; $display("FAIL integ_ready: got %b, want 010010", req_ready); end
      drive(1'b0, 1'b0, 6'h00, er);
      checks++;
      if (rs_rdy[0] !== 1'b0 || rs_rdy[1] !== 1'b0) begin
         errors++; $display("FAIL integ_early: got rdy=%b%b, want 00", rs_rdy[0], rs_rdy[1]);
      end
      @(posedge clk); #1;
      checks++;
      if (rs_rdy[0] !== 1'b1 || rs_val[0] !== 16'h1234) begin
         errors++; $display("FAIL integ_rob7: got rdy=%b val=%h, want rdy=1 val=1234", rs_rdy[0], rs_val[0]);
      end
      checks++;
      if (rs_rdy[1] !== 1'b1 || rs_val[1] !== 16'h5678) begin
         errors++; $display("FAIL integ_rob9: got rdy=%b val=%h, want rdy=1 val=5678", rs_rdy[1], rs_val[1]);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_oversub();
      test_flush();
      test_back_to_back();
      test_starvation();
      test_integration();
      @(posedge clk); #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
